// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one bus request at a time and hands the
// captured instruction to decode through a valid/stall handshake. Redirects squash stale fetches.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StDrop,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [63:0] out_pc_q, out_pc_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (redirect_valid) begin
      // A redirect outranks everything; only the bus bookkeeping decides REQ vs DROP.
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      unique case (state_q)
        StReq:   state_d = iresp_addr_ok ? StDrop : StReq;
        StWait:  state_d = iresp_data_ok ? StReq : StDrop;
        StDrop:  state_d = iresp_data_ok ? StReq : StDrop;
        StHold:  state_d = StReq;
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (iresp_addr_ok) state_d = StWait;
        end
        StWait: begin
          if (iresp_data_ok) begin
            out_instr_d = iresp_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 64'd4;
            state_d     = StHold;
          end
        end
        StDrop: begin
          if (iresp_data_ok) state_d = StReq;
        end
        StHold: begin
          if (!stall) begin
            out_valid_d = 1'b0;
            state_d     = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign ireq_valid = (state_q == StReq);
  assign ireq_addr  = pc_q;
  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: per-cycle input/expected-output records plus
// hand-written asynchronous-reset sequences.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h1234_5678;
  localparam logic [31:0] I2 = 32'hA5A5_5A5A;
  localparam logic [31:0] I3 = 32'h0BAD_F00D;
  localparam logic [31:0] I4 = 32'hCAFE_0001;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
    logic        redir;
    logic [63:0] rpc;
    logic        stl;
    logic        e_ivalid;
    logic [63:0] e_iaddr;
    logic        e_ovalid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ao, input logic dok, input logic [31:0] d, input logic rv,
                     input logic [63:0] rp, input logic st, input logic eiv,
                     input logic [63:0] eia, input logic eov, input logic [31:0] ein,
                     input logic [63:0] epc);
    vec_t v;
    v.addr_ok = ao;  v.data_ok = dok; v.data = d;   v.redir = rv;   v.rpc = rp;  v.stl = st;
    v.e_ivalid = eiv; v.e_iaddr = eia; v.e_ovalid = eov; v.e_instr = ein; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ao, input logic dok, input logic [31:0] d, input logic rv,
                       input logic [63:0] rp, input logic st);
    iresp_addr_ok  = ao;
    iresp_data_ok  = dok;
    iresp_data     = d;
    redirect_valid = rv;
    redirect_pc    = rp;
    stall          = st;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".ireq_valid"}, {63'd0, ireq_valid}, 64'd1);
    check({tag, ".ireq_addr"},  ireq_addr, RST_PC);
    check({tag, ".out_valid"},  {63'd0, out_valid}, 64'd0);
    check({tag, ".out_instr"},  {32'd0, out_instr}, 64'd0);
    check({tag, ".out_pc"},     out_pc, 64'd0);
  endtask

  initial begin
    // Outputs are Moore-style, so each record lists what must be visible this cycle and
    // the inputs to present before the next rising edge.
    //   ao dok data rv rpc  st | ivalid iaddr  ovalid instr pc
    add(1, 0, 0,  0, 0, 0,  1, RST_PC,       0, 0,  0);          // REQ
    add(0, 1, I0, 0, 0, 0,  0, RST_PC,       0, 0,  0);          // WAIT
    add(0, 0, 0,  0, 0, 0,  0, RST_PC + 4,   1, I0, RST_PC);     // HOLD
    add(1, 0, 0,  0, 0, 0,  1, RST_PC + 4,   0, I0, RST_PC);
    add(0, 1, I1, 0, 0, 0,  0, RST_PC + 4,   0, I0, RST_PC);
    add(0, 0, 0,  0, 0, 0,  0, RST_PC + 8,   1, I1, RST_PC + 4);
    add(1, 0, 0,  0, 0, 0,  1, RST_PC + 8,   0, I1, RST_PC + 4);
    add(0, 1, I2, 0, 0, 0,  0, RST_PC + 8,   0, I1, RST_PC + 4);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 1, 0, RST_PC + 12, 1, I2, RST_PC + 8);
    add(0, 0, 0,  0, 0, 0,  0, RST_PC + 12,  1, I2, RST_PC + 8); // stall drops
    add(1, 0, 0,  0, 0, 0,  1, RST_PC + 12,  0, I2, RST_PC + 8);
    // Redirect in WAIT, then the stale data (DEADBEEF) must be dropped.
    add(0, 0, 0,  1, 64'h8000_1000, 0, 0, RST_PC + 12, 0, I2, RST_PC + 8);
    add(0, 1, BAD, 0, 0, 0, 0, 64'h8000_1000, 0, I2, RST_PC + 8);
    // Redirect in REQ without addr_ok.
    add(0, 0, 0,  1, 64'h8000_2000, 0, 1, 64'h8000_1000, 0, I2, RST_PC + 8);
    add(1, 0, 0,  0, 0, 0,  1, 64'h8000_2000, 0, I2, RST_PC + 8);
    add(0, 1, I3, 0, 0, 0,  0, 64'h8000_2000, 0, I2, RST_PC + 8);
    // Redirect to the top of the address space in the cycle HOLD sees stall=0.
    add(0, 0, 0,  1, TOP_PC, 0, 0, 64'h8000_2004, 1, I3, 64'h8000_2000);
    add(1, 0, 0,  0, 0, 0,  1, TOP_PC, 0, I3, 64'h8000_2000);
    add(0, 1, I4, 0, 0, 0,  0, TOP_PC, 0, I3, 64'h8000_2000);
    add(0, 0, 0,  0, 0, 0,  0, 64'd0,  1, I4, TOP_PC);
    // Redirect in REQ with addr_ok goes to DROP; a second redirect while in DROP.
    add(1, 0, 0,  1, 64'h8000_3000, 0, 1, 64'd0, 0, I4, TOP_PC);
    add(0, 0, 0,  1, 64'h8000_4000, 0, 0, 64'h8000_3000, 0, I4, TOP_PC);
    add(0, 1, BAD, 0, 0, 0, 0, 64'h8000_4000, 0, I4, TOP_PC);
    add(1, 0, 0,  0, 0, 0,  1, 64'h8000_4000, 0, I4, TOP_PC);
    // Redirect coincides with data_ok in WAIT: data discarded, straight back to REQ.
    add(0, 1, BAD, 1, 64'h8000_5000, 0, 0, 64'h8000_4000, 0, I4, TOP_PC);
    add(1, 0, 0,  0, 0, 0,  1, 64'h8000_5000, 0, I4, TOP_PC);
    add(0, 0, 0,  0, 0, 0,  0, 64'h8000_5000, 0, I4, TOP_PC);    // WAIT, no data yet

    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("v%0d.ireq_valid", i), {63'd0, ireq_valid}, {63'd0, vecs[i].e_ivalid});
      check($sformatf("v%0d.ireq_addr", i),  ireq_addr, vecs[i].e_iaddr);
      check($sformatf("v%0d.out_valid", i),  {63'd0, out_valid}, {63'd0, vecs[i].e_ovalid});
      check($sformatf("v%0d.out_instr", i),  {32'd0, out_instr}, {32'd0, vecs[i].e_instr});
      check($sformatf("v%0d.out_pc", i),     out_pc, vecs[i].e_pc);
      drive(vecs[i].addr_ok, vecs[i].data_ok, vecs[i].data, vecs[i].redir, vecs[i].rpc,
            vecs[i].stl);
      @(negedge clk);
      #1;
    end

    // Still in WAIT: asynchronous reset must take effect before any clock edge.
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_reset_state("reset_in_wait");
    @(negedge clk);
    reset = 1'b0;
    #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    drive(0, 1, I1, 0, 0, 0);
    @(negedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 1);
    check("hold.out_valid", {63'd0, out_valid}, 64'd1);
    check("hold.out_pc", out_pc, RST_PC);
    check("hold.out_instr", {32'd0, out_instr}, {32'd0, I1});
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("reset_in_hold");
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
